// File: rtl/sme_pkg.sv
// Shared constants, defaults and FSM encoding for the string matching engine host.
package sme_pkg;

  localparam logic [7:0] CHAR_HEAD  = 8'h5E;
  localparam logic [7:0] CHAR_TAIL  = 8'h24;
  localparam logic [7:0] CHAR_DOT   = 8'h2E;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam int unsigned SME_STR_MAX = 32;
  localparam int unsigned SME_PAT_MAX = 10;

  typedef enum logic [2:0] {
    StIdle,
    StSendStr,
    StSendPat,
    StWait,
    StDone
  } sme_state_e;

endpackage

// File: rtl/sme_host_if.sv
// Engine-facing link: host streams chars, engine answers with a result.
interface sme_host_if;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid;
  logic       match;
  logic [4:0] match_index;

  modport master (
    output chardata, isstring, ispattern,
    input  valid, match, match_index
  );

  modport slave (
    input  chardata, isstring, ispattern,
    output valid, match, match_index
  );
endinterface

// File: rtl/sme_char_buf.sv
// Character buffer: one synchronous write port, one combinational read port, async clear.
module sme_char_buf #(
  parameter int unsigned Depth = 8,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem_q [Depth];

  // Storage; out-of-range writes are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (we && (32'(waddr) < Depth)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port; out-of-range addresses return 0.
  always_comb begin
    rdata = '0;
    if (32'(raddr) < Depth) rdata = mem_q[raddr];
  end

endmodule

// File: rtl/sme_host.sv
// Host-side driver: buffers string/pattern, streams them to the engine, captures the result.
module sme_host
  import sme_pkg::*;
#(
  parameter int unsigned STR_MAX = SME_STR_MAX,
  parameter int unsigned PAT_MAX = SME_PAT_MAX,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] str_len,
  input  logic [3:0] pat_len,
  input  logic       send_str,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  sme_host_if.master eng
);

  localparam int unsigned StrAw = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int unsigned PatAw = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

  sme_state_e state_q, state_d;
  logic [5:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] slen_q, slen_d;
  logic [3:0] plen_q, plen_d;
  logic [7:0] chardata_q, chardata_d;
  logic       isstring_q, isstring_d, ispattern_q, ispattern_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       res_match_q, res_match_d, res_timeout_q, res_timeout_d;
  logic [4:0] res_index_q, res_index_d;

  logic             str_we, pat_we, start_ok;
  logic [StrAw-1:0] str_raddr;
  logic [PatAw-1:0] pat_raddr;
  logic [7:0]       str_rdata, pat_rdata;

  // Buffers are writable only in IDLE so they stay stable while streaming.
  assign str_we = wr_en && !wr_sel && (state_q == StIdle) && (32'(wr_addr) < STR_MAX);
  assign pat_we = wr_en &&  wr_sel && (state_q == StIdle) && (32'(wr_addr) < PAT_MAX);

  assign start_ok = (pat_len != '0) && (32'(pat_len) <= PAT_MAX) &&
                    (!send_str || ((str_len != '0) && (32'(str_len) <= STR_MAX)));

  // Read index 0 outside the matching send state so the first char of the next phase is ready.
  assign str_raddr = (state_q == StSendStr) ? StrAw'(ptr_q) : '0;
  assign pat_raddr = (state_q == StSendPat) ? PatAw'(ptr_q) : '0;

  sme_char_buf #(.Depth(STR_MAX), .AddrW(StrAw)) u_str_buf (
    .clk   (clk),
    .reset (reset),
    .we    (str_we),
    .waddr (StrAw'(wr_addr)),
    .wdata (wr_data),
    .raddr (str_raddr),
    .rdata (str_rdata)
  );

  sme_char_buf #(.Depth(PAT_MAX), .AddrW(PatAw)) u_pat_buf (
    .clk   (clk),
    .reset (reset),
    .we    (pat_we),
    .waddr (PatAw'(wr_addr)),
    .wdata (wr_data),
    .raddr (pat_raddr),
    .rdata (pat_rdata)
  );

  // Next state; engine-facing outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    slen_d        = slen_q;
    plen_d        = plen_q;
    chardata_d    = '0;
    isstring_d    = 1'b0;
    ispattern_d   = 1'b0;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_timeout_d = res_timeout_q;
    unique case (state_q)
      StIdle: begin
        if (start && start_ok) begin
          slen_d = str_len;
          plen_d = pat_len;
          ptr_d  = 6'd1;
          if (send_str) begin
            state_d    = StSendStr;
            isstring_d = 1'b1;
            chardata_d = str_rdata;
          end else begin
            state_d     = StSendPat;
            ispattern_d = 1'b1;
            chardata_d  = pat_rdata;
          end
        end
      end
      StSendStr: begin
        if (ptr_q < slen_q) begin
          isstring_d = 1'b1;
          chardata_d = str_rdata;
          ptr_d      = ptr_q + 6'd1;
        end else begin
          state_d     = StSendPat;
          ispattern_d = 1'b1;
          chardata_d  = pat_rdata;
          ptr_d       = 6'd1;
        end
      end
      StSendPat: begin
        if (ptr_q < {2'b00, plen_q}) begin
          ispattern_d = 1'b1;
          chardata_d  = pat_rdata;
          ptr_d       = ptr_q + 6'd1;
        end else begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (eng.valid) begin
          state_d       = StDone;
          res_match_d   = eng.match;
          res_index_d   = eng.match ? eng.match_index : '0;
          res_timeout_d = 1'b0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d       = StDone;
          res_match_d   = 1'b0;
          res_index_d   = '0;
          res_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StSendStr) || (state_d == StSendPat) || (state_d == StWait);
    done_d = (state_d == StDone);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      cnt_q         <= '0;
      slen_q        <= '0;
      plen_q        <= '0;
      chardata_q    <= '0;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      slen_q        <= slen_d;
      plen_q        <= plen_d;
      chardata_q    <= chardata_d;
      isstring_q    <= isstring_d;
      ispattern_q   <= ispattern_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign eng.chardata  = chardata_q;
  assign eng.isstring  = isstring_q;
  assign eng.ispattern = ispattern_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign res_match     = res_match_q;
  assign res_index     = res_index_q;
  assign res_timeout   = res_timeout_q;

endmodule

// File: tb/tb_sme_host.sv
// Scoreboard bench for sme_host: stimulus queues expected chars/results, a monitor checks them.
module tb_sme_host;
  import sme_pkg::*;

  typedef struct {
    logic       m;
    logic [4:0] idx;
    logic       to;
    int         wait_cyc;  // -1: don't care
  } res_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, wr_sel, send_str, start;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic       busy, done, res_match, res_timeout;
  logic [4:0] res_index;

  logic [9:0] exp_ch [$];
  res_t       exp_res [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         mon_en   = 1'b0;
  int         wait_cnt = 0;

  sme_host_if eng ();

  sme_host #(.STR_MAX(32), .PAT_MAX(10), .TIMEOUT(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .str_len     (str_len),
    .pat_len     (pat_len),
    .send_str    (send_str),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .res_match   (res_match),
    .res_index   (res_index),
    .res_timeout (res_timeout),
    .eng         (eng)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a char or a done pulse.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (eng.isstring || eng.ispattern) begin
        if (exp_ch.size() == 0) begin
          chk("unexpected_char", {22'b0, eng.isstring, eng.ispattern, eng.chardata}, 32'h0);
        end else begin
          chk("char", {22'b0, eng.isstring, eng.ispattern, eng.chardata},
              {22'b0, exp_ch.pop_front()});
        end
      end
      if (busy && !eng.isstring && !eng.ispattern) wait_cnt++;
      if (done) begin
        if (exp_res.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'h0);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          chk("res_match", 32'(res_match), 32'(r.m));
          chk("res_index", 32'(res_index), 32'(r.idx));
          chk("res_timeout", 32'(res_timeout), 32'(r.to));
          chk("busy_at_done", 32'(busy), 32'h0);
          if (r.wait_cyc >= 0) chk("wait_cycles", 32'(wait_cnt), 32'(r.wait_cyc));
        end
        wait_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load(input logic sel, input string s);
    for (int i = 0; i < s.len(); i++) wr(sel, 5'(i), s[i]);
  endtask

  task automatic exp_stream(input logic is_str, input string s);
    for (int i = 0; i < s.len(); i++) exp_ch.push_back({is_str, !is_str, s[i]});
  endtask

  task automatic push_res(input logic m, input logic [4:0] idx, input logic to, input int w);
    res_t r;
    r.m = m; r.idx = idx; r.to = to; r.wait_cyc = w;
    exp_res.push_back(r);
  endtask

  task automatic go(input logic ss, input logic [5:0] sl, input logic [3:0] pl);
    send_str = ss; str_len = sl; pat_len = pl; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_wait();
    int n = 0;
    while (!(busy && !eng.isstring && !eng.ispattern) && n < 100) begin
      tick();
      n++;
    end
    chk("reach_wait", 32'(n < 100), 32'h1);
  endtask

  task automatic engine(input int lat, input logic m, input logic [4:0] idx);
    repeat (lat) tick();
    eng.valid = 1'b1; eng.match = m; eng.match_index = idx;
    tick();
    eng.valid = 1'b0; eng.match = 1'b0; eng.match_index = '0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 32'h1);
    tick();
  endtask

  initial begin
    reset = 1'b1; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0;
    str_len = 0; pat_len = 0; send_str = 0; start = 0;
    eng.valid = 0; eng.match = 0; eng.match_index = 0;
    repeat (2) tick();
    chk("rst_outputs", {busy, done, res_match, res_index, res_timeout, eng.chardata,
                        eng.isstring, eng.ispattern}, 32'h0);
    reset = 1'b0;
    tick();
    mon_en = 1'b1;

    // Full send; a write and a second start during SEND_STR must be ignored.
    load(1'b0, "abc de");
    load(1'b1, "d");
    exp_stream(1'b1, "abc de");
    exp_stream(1'b0, "d");
    push_res(1'b1, 5'd4, 1'b0, 4);
    go(1'b1, 6'd6, 4'd1);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd1; wr_data = "Z";
    send_str = 1'b0; pat_len = 4'd3; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    wait_wait();
    engine(3, 1'b1, 5'd4);
    wait_done(20);

    // Pattern only with markers; engine answers in the first WAIT cycle.
    load(1'b1, "^de$");
    exp_stream(1'b0, "^de$");
    push_res(1'b1, 5'd4, 1'b0, 1);
    go(1'b0, 6'd6, 4'd4);
    wait_wait();
    engine(0, 1'b1, 5'd4);
    wait_done(20);

    // Rejected starts: bad pat_len / str_len.
    go(1'b1, 6'd6, 4'd0);
    repeat (3) tick();
    chk("rej_patlen0_busy", 32'(busy), 32'h0);
    go(1'b1, 6'd0, 4'd1);
    repeat (3) tick();
    chk("rej_strlen0_busy", 32'(busy), 32'h0);
    go(1'b1, 6'd33, 4'd1);
    repeat (3) tick();
    chk("rej_strlen33_busy", 32'(busy), 32'h0);
    go(1'b0, 6'd0, 4'd11);
    repeat (3) tick();
    chk("rej_patlen11_busy", 32'(busy), 32'h0);

    // Timeout; string resent to confirm the ignored write left 'b' in place.
    exp_stream(1'b1, "abc de");
    exp_stream(1'b0, "^de$");
    push_res(1'b0, 5'd0, 1'b1, 255);
    go(1'b1, 6'd6, 4'd4);
    wait_done(400);

    // Reset during SEND_PAT aborts with everything cleared.
    mon_en = 1'b0;
    go(1'b0, 6'd6, 4'd4);
    chk("abort_pat0", {23'b0, eng.ispattern, eng.chardata}, {23'b0, 1'b1, CHAR_HEAD});
    tick();
    chk("abort_pat1", {23'b0, eng.ispattern, eng.chardata}, {23'b0, 1'b1, 8'h64});
    reset = 1'b1;
    #1;
    chk("abort_outputs", {busy, done, res_match, res_index, res_timeout, eng.chardata,
                          eng.isstring, eng.ispattern}, 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_done", {30'b0, done, busy}, 32'h0);
    end
    mon_en = 1'b1;
    wait_cnt = 0;

    // Buffers were cleared by reset: pattern char 0 now reads back as 0x00.
    exp_ch.push_back({1'b0, 1'b1, 8'h00});
    push_res(1'b1, 5'd2, 1'b0, 2);
    go(1'b0, 6'd6, 4'd1);
    wait_wait();
    engine(1, 1'b1, 5'd2);
    wait_done(20);

    // Fresh load; valid during SEND_STR ignored, no-match result forces index 0.
    load(1'b0, "abc de");
    load(1'b1, "de");
    exp_stream(1'b1, "abc de");
    exp_stream(1'b0, "de");
    push_res(1'b0, 5'd0, 1'b0, 3);
    go(1'b1, 6'd6, 4'd2);
    tick();
    eng.valid = 1'b1; eng.match = 1'b1; eng.match_index = 5'd3;
    tick();
    eng.valid = 1'b0; eng.match = 1'b0; eng.match_index = '0;
    wait_wait();
    engine(2, 1'b0, 5'd7);
    wait_done(20);

    repeat (3) tick();
    chk("exp_ch_drained", 32'(exp_ch.size()), 32'h0);
    chk("exp_res_drained", 32'(exp_res.size()), 32'h0);
    chk("final_res", {25'b0, res_match, res_index, res_timeout}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sme_host.md
# sme_host

Host-side driver for the string matching engine: holds one string (up to 32 chars) and one pattern (up to 8 chars plus optional `^`/`$` markers) in local buffers loaded through a write port. On `start` it streams them to the engine on `chardata`/`isstring`/`ispattern` and waits for the engine's `valid`. It then captures `match`/`match_index` into result registers and signals `done`. It sits between the CPU/testbench register interface and the engine, and owns the engine-facing side of the protocol.

## Interface
Parameters:
- `STR_MAX`, default 32: string buffer depth in chars.
- `PAT_MAX`, default 10: pattern buffer depth in chars, including `^` and `$`.
- `TIMEOUT`, default 255: maximum WAIT cycles before giving up; 8-bit counter.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `wr_en`, in, 1: buffer write strobe.
- `wr_sel`, in, 1: write target; 0 = string buffer, 1 = pattern buffer.
- `wr_addr`, in, 5: buffer address.
- `wr_data`, in, 8: character to write.
- `str_len`, in, 6: number of string chars to send (1..32).
- `pat_len`, in, 4: number of pattern chars to send, markers included (1..10).
- `send_str`, in, 1: 1 = send string and pattern; 0 = pattern only, so the engine reuses its stored string.
- `start`, in, 1: launch one transaction.
- `busy`, out, 1: transaction in progress.
- `done`, out, 1: one-cycle completion pulse.
- `res_match`, out, 1: captured match result.
- `res_index`, out, 5: captured match position.
- `res_timeout`, out, 1: the engine never asserted `valid`.
- `chardata`, out, 8: character to the engine.
- `isstring`, out, 1: `chardata` is a string char.
- `ispattern`, out, 1: `chardata` is a pattern char.
- `valid`, in, 1: engine result valid.
- `match`, in, 1: engine match flag.
- `match_index`, in, 5: engine match position.

## Operation
- FSM states: IDLE, SEND_STR, SEND_PAT, WAIT, DONE.
- IDLE:
  - `wr_en` writes `wr_data` into the buffer selected by `wr_sel`. Writes with `wr_addr` ≥ that buffer's depth are dropped.
  - `start` is accepted only if `pat_len` is in 1..PAT_MAX and, when `send_str`=1, `str_len` is in 1..STR_MAX. Otherwise `start` is ignored: no state change and no `done`.
  - Accepted `start` → SEND_STR if `send_str`=1, else SEND_PAT. The read pointer clears to 0.
- SEND_STR: drive `isstring`=1 and `chardata`=str_buf[ptr]. Increment ptr. After `str_len` chars, ptr resets and the FSM goes to SEND_PAT.
- SEND_PAT: drive `ispattern`=1 and `chardata`=pat_buf[ptr]. After `pat_len` chars → WAIT.
- Pattern bytes, including `^` (0x5E), `$` (0x24) and `.` (0x2E), are sent verbatim. The host does not validate marker placement.
- WAIT: `isstring`=`ispattern`=0 and `chardata`=0. The timeout counter increments each cycle.
  - `valid`=1 → capture `res_match`=`match`, `res_index`=`match ? match_index : 0`, `res_timeout`=0 → DONE.
  - Counter reaches TIMEOUT with no `valid` → `res_match`=0, `res_index`=0, `res_timeout`=1 → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Result registers hold their values until the next DONE or reset.
- `valid` in any state other than WAIT is ignored.
- `start` while not in IDLE is ignored.
- `wr_en` while not in IDLE is ignored, so the buffers are stable during streaming.

## Timing
- Reset (asynchronous) values:
  - All outputs 0: `busy`, `done`, `res_match`, `res_index`, `res_timeout`, `chardata`, `isstring`, `ispattern`.
  - Both buffers cleared to 0; FSM to IDLE; pointer and counter cleared.
- Reset mid-transaction aborts immediately, with no `done`.
- All engine-facing outputs are registered. The first char appears the cycle after `start` is sampled.
- Chars are sent back-to-back with no gap between the last string char and the first pattern char.
- `ispattern` is asserted exactly `pat_len` cycles; `isstring` exactly `str_len` cycles, or 0 cycles when `send_str`=0.
- `busy`=1 in SEND_STR, SEND_PAT and WAIT; 0 in IDLE and DONE.
- `done` asserts the cycle after `valid` is sampled in WAIT. Result registers update on the same edge.
- Minimum start-to-done latency = `str_len` + `pat_len` + (engine latency) + 2 cycles.
- A new `start` is accepted in the first IDLE cycle after DONE.

## Structure
- Shared package `sme_pkg`:
  - char constants CHAR_HEAD=8'h5E, CHAR_TAIL=8'h24, CHAR_DOT=8'h2E, CHAR_SPACE=8'h20;
  - FSM state encoding;
  - STR_MAX and PAT_MAX defaults.
- Sub-module `sme_char_buf`: parameterized depth, with one synchronous write port, one combinational read port and async clear. It is instantiated twice, once for the string buffer and once for the pattern buffer.

## Test plan
- Load string "abc de" (6 chars) and pattern "d" (1 char); start with `send_str`=1 → `isstring` high 6 cycles carrying 61 62 63 20 64 65, then `ispattern` high 1 cycle carrying 64. Engine returns match=1, index=4 → `done` pulse, `res_match`=1, `res_index`=4.
- Pattern "^de$" (4 chars) with `send_str`=0 → `isstring` never asserted; `ispattern` carries 5E 64 65 24. Engine returns match=1, index=4 → results captured.
- Engine model never asserts `valid` → `done` after 255 WAIT cycles with `res_timeout`=1, `res_match`=0, `res_index`=0.
- `start` with `pat_len`=0, and `start` while `busy` → no output activity and no `done`. A `wr_en` issued during SEND_STR leaves the buffer contents unchanged.
- Assert `reset` during SEND_PAT → all outputs 0 next sample, no `done`. A following fresh load and start completes normally.
- Engine pulses `valid` during SEND_STR → ignored. The later `valid` in WAIT with match=0 and match_index=7 → `res_match`=0, `res_index`=0.
